// File: rtl/thermostat_display_scheduler.sv
// thermostat_display_scheduler
//
// Sits between the thermostat packet deserializer and the shared
// binary-to-BCD converter that feeds the seven-segment display.
//   * Validates each completed packet (preamble + constant field) and loads
//     accepted room/set/state values into a shadow buffer.
//   * Rotates room -> set -> state through the converter with a start/done
//     handshake, holding each field on the display for a dwell period.
//   * Blanks the display once packets stop arriving and counts rejects.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   frame_full        one-cycle pulse, packet fields below are complete
//   preamble/constant packet check fields (32 bit each)
//   room_temp/set_temp/state  packet payload (16/16/8 bit)
//   bcd_binary        value presented to the converter (held while busy)
//   bcd_start         one-cycle conversion request
//   bcd_done          one-cycle conversion completion from the converter
//   field_sel         field being shown: 0 room, 1 set, 2 state
//   display_blank     display should be blank
//   frame_valid       shadow buffer holds a non-stale accepted packet
//   error_count       rejected packets, saturating at 255
module thermostat_display_scheduler #(
  parameter logic [31:0] PREAMBLE_VALUE = 32'h0000_0000,
  parameter logic [31:0] CONSTANT_VALUE = 32'h0000_0000,
  parameter int unsigned DWELL_CYCLES   = 32'd1_000_000,
  parameter int unsigned STALE_CYCLES   = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_full,
  input  logic [31:0] preamble,
  input  logic [31:0] constant,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  output logic [15:0] bcd_binary,
  output logic        bcd_start,
  input  logic        bcd_done,
  output logic [1:0]  field_sel,
  output logic        display_blank,
  output logic        frame_valid,
  output logic [7:0]  error_count
);

  // Dwell counter must be able to hold DWELL_CYCLES itself; the stale
  // counter never exceeds STALE_CYCLES-1.
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 32'd1);
  localparam int unsigned SW = $clog2(STALE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1'b1);
  localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CYCLES - 32'd1);
  localparam logic [SW-1:0] STALE_ONE  = SW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DWELL = 2'd3
  } fsm_state_t;

  // Shadow field selected for conversion; the state byte is zero-extended.
  function automatic logic [15:0] field_value(
    input logic [1:0]  sel,
    input logic [15:0] room,
    input logic [15:0] setp,
    input logic [7:0]  st
  );
    logic [15:0] v;
    case (sel)
      2'd0:    v = room;
      2'd1:    v = setp;
      2'd2:    v = {8'h00, st};
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  fsm_state_t  fsm_r, fsm_nxt_s;
  logic [15:0] room_r, set_r;
  logic [7:0]  state_r;
  logic [SW-1:0] stale_cnt_r, stale_cnt_nxt_s;
  logic [DW-1:0] dwell_cnt_r, dwell_cnt_nxt_s;
  logic        restart_r, restart_nxt_s, restart_clr_s;
  logic        accept_s, reject_s, stale_hit_s, frame_valid_nxt_s;
  logic [7:0]  error_count_nxt_s;
  logic [1:0]  field_sel_nxt_s;
  logic [15:0] bcd_binary_nxt_s;
  logic        bcd_start_nxt_s, blank_fsm_s, display_blank_nxt_s;

  assign accept_s    = frame_full & (preamble == PREAMBLE_VALUE) & (constant == CONSTANT_VALUE);
  assign reject_s    = frame_full & ~accept_s;
  assign stale_hit_s = frame_valid & (stale_cnt_r == STALE_LAST);

  // Packet acceptance, staleness and restart bookkeeping. An accept on the
  // expiry cycle takes priority so the buffer never goes stale under it.
  always_comb begin
    frame_valid_nxt_s = frame_valid;
    stale_cnt_nxt_s   = stale_cnt_r;
    restart_nxt_s     = restart_r;
    error_count_nxt_s = error_count;
    if (accept_s) begin
      frame_valid_nxt_s = 1'b1;
      stale_cnt_nxt_s   = {SW{1'b0}};
      restart_nxt_s     = 1'b1;
    end else if (stale_hit_s) begin
      frame_valid_nxt_s = 1'b0;
      stale_cnt_nxt_s   = {SW{1'b0}};
      restart_nxt_s     = 1'b0;
    end else begin
      if (frame_valid) begin
        stale_cnt_nxt_s = stale_cnt_r + STALE_ONE;
      end else begin
        stale_cnt_nxt_s = stale_cnt_r;
      end
      if (restart_clr_s) begin
        restart_nxt_s = 1'b0;
      end else begin
        restart_nxt_s = restart_r;
      end
    end
    if (reject_s && (error_count != 8'hFF)) begin
      error_count_nxt_s = error_count + 8'd1;
    end else begin
      error_count_nxt_s = error_count;
    end
  end

  // Display rotation FSM: next state and next values of all registered outputs.
  always_comb begin
    fsm_nxt_s        = fsm_r;
    field_sel_nxt_s  = field_sel;
    bcd_binary_nxt_s = bcd_binary;
    bcd_start_nxt_s  = 1'b0;
    blank_fsm_s      = display_blank;
    dwell_cnt_nxt_s  = dwell_cnt_r;
    restart_clr_s    = 1'b0;
    case (fsm_r)
      ST_IDLE: begin
        blank_fsm_s = 1'b1;
        if (frame_valid) begin
          fsm_nxt_s        = ST_START;
          field_sel_nxt_s  = 2'd0;
          restart_clr_s    = 1'b1;
          bcd_start_nxt_s  = 1'b1;
          bcd_binary_nxt_s = field_value(2'd0, room_r, set_r, state_r);
        end else begin
          fsm_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        fsm_nxt_s = ST_BUSY;
      end
      ST_BUSY: begin
        // The handshake always completes; a stale buffer only changes
        // where we go once the converter answers.
        if (bcd_done) begin
          if (frame_valid_nxt_s) begin
            fsm_nxt_s       = ST_DWELL;
            dwell_cnt_nxt_s = {DW{1'b0}};
            blank_fsm_s     = 1'b0;
          end else begin
            fsm_nxt_s = ST_IDLE;
          end
        end else begin
          fsm_nxt_s = ST_BUSY;
        end
      end
      ST_DWELL: begin
        if (dwell_cnt_r == DWELL_LAST) begin
          if (!frame_valid_nxt_s) begin
            fsm_nxt_s = ST_IDLE;
          end else begin
            if (restart_r) begin
              field_sel_nxt_s = 2'd0;
              restart_clr_s   = 1'b1;
            end else begin
              case (field_sel)
                2'd0:    field_sel_nxt_s = 2'd1;
                2'd1:    field_sel_nxt_s = 2'd2;
                default: field_sel_nxt_s = 2'd0;
              endcase
            end
            fsm_nxt_s        = ST_START;
            bcd_start_nxt_s  = 1'b1;
            bcd_binary_nxt_s = field_value(field_sel_nxt_s, room_r, set_r, state_r);
          end
        end else begin
          dwell_cnt_nxt_s = dwell_cnt_r + DWELL_ONE;
        end
      end
      default: begin
        fsm_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Losing the buffer blanks the display immediately, whatever the FSM does.
  assign display_blank_nxt_s = blank_fsm_s | ~frame_valid_nxt_s;

  // Packet-side registers: shadow buffer, validity, stale timer, error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      room_r      <= 16'h0000;
      set_r       <= 16'h0000;
      state_r     <= 8'h00;
      frame_valid <= 1'b0;
      stale_cnt_r <= {SW{1'b0}};
      restart_r   <= 1'b0;
      error_count <= 8'h00;
    end else begin
      if (accept_s) begin
        room_r  <= room_temp;
        set_r   <= set_temp;
        state_r <= state;
      end
      frame_valid <= frame_valid_nxt_s;
      stale_cnt_r <= stale_cnt_nxt_s;
      restart_r   <= restart_nxt_s;
      error_count <= error_count_nxt_s;
    end
  end

  // FSM state and registered converter/display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r         <= ST_IDLE;
      dwell_cnt_r   <= {DW{1'b0}};
      field_sel     <= 2'd0;
      bcd_binary    <= 16'h0000;
      bcd_start     <= 1'b0;
      display_blank <= 1'b1;
    end else begin
      fsm_r         <= fsm_nxt_s;
      dwell_cnt_r   <= dwell_cnt_nxt_s;
      field_sel     <= field_sel_nxt_s;
      bcd_binary    <= bcd_binary_nxt_s;
      bcd_start     <= bcd_start_nxt_s;
      display_blank <= display_blank_nxt_s;
    end
  end

endmodule
